// File: rtl/countdown_pkg.sv
// Shared types and constants for the minute countdown timer.
package countdown_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Limit a user-supplied digit to the legal BCD range.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down counter (00-99) with clear, load and saturating decrement.
module bcd2_down_counter
    import countdown_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_ones,
    input  logic             dec_en,
    input  logic             clear_en,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             is_one,
    output logic             is_zero
);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    // Next count: clear > load > decrement; decrement holds at 00.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clear_en) begin
            tens_d = '0;
            ones_d = '0;
        end else if (load_en) begin
            tens_d = load_tens;
            ones_d = load_ones;
        end else if (dec_en && !is_zero) begin
            if (ones_q != '0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = BCD_MAX;
                tens_d = tens_q - 4'd1;
            end
        end
    end

    // Count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign is_zero = (tens_q == '0) && (ones_q == '0);
    assign is_one  = (tens_q == '0) && (ones_q == 4'd1);

endmodule

// File: rtl/countdown_timer_core.sv
// Minute countdown engine: control FSM, command priority and alarm timeout.
module countdown_timer_core
    import countdown_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       min_tick,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int unsigned AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_TICKS);

    state_t        state_q, state_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          alarm_q, alarm_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;

    logic cnt_clear, cnt_load, cnt_dec;
    logic cnt_is_one, cnt_is_zero;

    bcd2_down_counter u_counter (
        .clk       (clk),
        .reset     (reset),
        .load_en   (cnt_load),
        .load_tens (bcd_clamp(preset_tens)),
        .load_ones (bcd_clamp(preset_ones)),
        .dec_en    (cnt_dec),
        .clear_en  (cnt_clear),
        .tens      (tens),
        .ones      (ones),
        .is_one    (cnt_is_one),
        .is_zero   (cnt_is_zero)
    );

    // Next state and counter controls; a command ignored in the current state
    // does not block lower-priority commands.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        if (clear) begin
            cnt_clear   = 1'b1;
            state_d     = ST_IDLE;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (load && state_q != ST_RUNNING) begin
            cnt_load    = 1'b1;
            state_d     = ST_IDLE;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSED) && !cnt_is_zero) begin
            state_d = ST_RUNNING;
            alarm_d = 1'b0;
        end else if (pause && state_q == ST_RUNNING) begin
            state_d = ST_PAUSED;
        end else if (min_tick) begin
            if (state_q == ST_RUNNING) begin
                cnt_dec = 1'b1;
                if (cnt_is_one) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    alarm_d     = 1'b1;
                    alarm_cnt_d = '0;
                end
            end else if (state_q == ST_DONE) begin
                if (ALARM_TICKS != 0 && alarm_cnt_q != ALARM_MAX) begin
                    alarm_cnt_d = alarm_cnt_q + AW'(1);
                    if (alarm_cnt_d == ALARM_MAX) begin
                        alarm_d = 1'b0;
                    end
                end
            end
        end

        running_d = (state_d == ST_RUNNING);
    end

    // Control registers; every output is taken straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            running_q   <= running_d;
            done_q      <= done_d;
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule
